// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - run/step request, instruction byte and decoded control strobes
// The sequencer is the slave; whoever drives run/step/inst_in is the master.
interface instr_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              run;
  logic              step;
  logic [7:0]        inst_in;
  logic              sel_pc;
  logic              mem_read;
  logic              ld_inst;
  logic              ld_inc;
  logic              sel_inc;
  logic              ld_pc;
  logic [7:0]        ld_reg;
  logic [7:0]        sel_reg;
  logic [2:0]        alu_func;
  logic              imm_en;
  logic [DATA_W-1:0] imm_out;
  logic [4:0]        state_num;
  logic              busy;
  logic              illegal;
  logic [CNT_W-1:0]  inst_count;

  modport master (
    output run, step, inst_in,
    input  sel_pc, mem_read, ld_inst, ld_inc, sel_inc, ld_pc,
    input  ld_reg, sel_reg, alu_func, imm_en, imm_out,
    input  state_num, busy, illegal, inst_count
  );

  modport slave (
    input  run, step, inst_in,
    output sel_pc, mem_read, ld_inst, ld_inc, sel_inc, ld_pc,
    output ld_reg, sel_reg, alu_func, imm_en, imm_out,
    output state_num, busy, illegal, inst_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fixed-length microcycle instruction sequencer (fetch, decode, execute)
// Every output is a flop loaded with the decode of the next state, so no input reaches an output combinationally.
module instr_sequencer #(
  parameter int CYCLES_PER_INST = 8,
  parameter int DATA_W          = 8,
  parameter int CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  instr_sequencer_if.slave bus
);

  localparam logic [4:0] LAST_CYC = 5'(CYCLES_PER_INST);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic              sel_pc;
    logic              mem_read;
    logic              ld_inst;
    logic              ld_inc;
    logic              sel_inc;
    logic              ld_pc;
    logic [7:0]        ld_reg;
    logic [7:0]        sel_reg;
    logic [2:0]        alu_func;
    logic              imm_en;
    logic [DATA_W-1:0] imm_out;
    logic              illegal;
  } out_t;

  state_e           state_q, state_d;
  logic [4:0]       cyc_q, cyc_d;
  logic [7:0]       ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_q, hold_d;
  out_t             out_q, out_d;

  function automatic out_t decode(input logic [4:0] s, input logic [7:0] ir);
    out_t o;
    o          = '0;
    o.alu_func = 3'b111;
    if (s >= 5'd1 && s <= 5'd3) begin
      o.sel_pc   = 1'b1;
      o.mem_read = 1'b1;
    end
    if (s == 5'd2) begin
      o.ld_inst = 1'b1;
      o.ld_inc  = 1'b1;
    end
    if (s == 5'd5 || s == 5'd6) o.sel_inc = 1'b1;
    if (s == 5'd5) o.ld_pc = 1'b1;
    if (s >= 5'd4 && s <= 5'd6) begin
      casez (ir)
        8'b00??????: begin
          if (s == 5'd5) o.ld_reg = 8'b1 << ir[5:3];
          if (s != 5'd4) o.sel_reg = 8'b1 << ir[2:0];
        end
        8'b01??????: begin
          o.imm_out = {{(DATA_W-5){ir[4]}}, ir[4:0]};
          if (s != 5'd4) o.imm_en = 1'b1;
          if (s == 5'd5) o.ld_reg = ir[5] ? 8'h02 : 8'h01;
        end
        8'b1000????: begin
          o.alu_func = ir[2:0];
          if (s == 5'd5) o.ld_reg = ir[3] ? 8'h08 : 8'h01;
        end
        default: begin
          if (s == 5'd4) o.illegal = 1'b1;
        end
      endcase
    end
    return o;
  endfunction

  // hold_q blocks a restart after a single step until run has been seen low.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.run) begin
          hold_d = 1'b0;
        end else if (!hold_q) begin
          state_d = ST_EXEC;
          cyc_d   = 5'd1;
        end
      end
      ST_EXEC: begin
        if (cyc_q == 5'd2) ir_d = bus.inst_in;
        if (cyc_q == LAST_CYC) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.run && !bus.step) begin
            cyc_d = 5'd1;
          end else begin
            state_d = ST_IDLE;
            cyc_d   = 5'd0;
            hold_d  = bus.step;
          end
        end else begin
          cyc_d = cyc_q + 5'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 5'd0;
      end
    endcase
    out_d = decode(cyc_d, ir_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= 5'd0;
      ir_q    <= 8'h00;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
      out_q   <= decode(5'd0, 8'h00);
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  assign bus.sel_pc     = out_q.sel_pc;
  assign bus.mem_read   = out_q.mem_read;
  assign bus.ld_inst    = out_q.ld_inst;
  assign bus.ld_inc     = out_q.ld_inc;
  assign bus.sel_inc    = out_q.sel_inc;
  assign bus.ld_pc      = out_q.ld_pc;
  assign bus.ld_reg     = out_q.ld_reg;
  assign bus.sel_reg    = out_q.sel_reg;
  assign bus.alu_func   = out_q.alu_func;
  assign bus.imm_en     = out_q.imm_en;
  assign bus.imm_out    = out_q.imm_out;
  assign bus.illegal    = out_q.illegal;
  assign bus.state_num  = cyc_q;
  assign bus.busy       = (cyc_q != 5'd0);
  assign bus.inst_count = cnt_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter CYCLES_PER_INST, default 8, meaning clock cycles per instruction; the legal range SHALL be 8..24.
REQ-002 Parameter DATA_W, default 8, meaning width of imm_out; DATA_W SHALL be >= 8.
REQ-003 Parameter CNT_W, default 16, meaning width of inst_count.
REQ-004 clk  input  1  meaning the single clock; all state changes SHALL occur on its rising edge.
REQ-005 reset  input  1  meaning reset; it SHALL be asynchronous and active-high.
REQ-006 run  input  1  meaning level request to execute instructions.
REQ-007 step  input  1  meaning single-step mode: execute one instruction per run request.
REQ-008 inst_in  input  8  meaning memory data bus, carrying the instruction byte.
REQ-009 sel_pc, mem_read, ld_inst, ld_inc, sel_inc, ld_pc  output  1 each  meaning fetch/PC control strobes.
REQ-010 ld_reg  output  8  meaning one-hot register load; bit index A=0, B=1, C=2, D=3, M1=4, M2=5, X=6, Y=7.
REQ-011 sel_reg  output  8  meaning one-hot register bus select, with the same indexing as ld_reg.
REQ-012 alu_func  output  3  meaning ALU function code; 3'b111 = ALU nop.
REQ-013 imm_en  output  1  meaning drive imm_out onto the data bus.
REQ-014 imm_out  output  DATA_W  meaning sign-extended SETAB immediate.
REQ-015 state_num  output  5  meaning 0 = IDLE, otherwise current cycle 1..CYCLES_PER_INST.
REQ-016 busy  output  1  meaning state_num != 0.
REQ-017 illegal  output  1  meaning one-cycle pulse when an unsupported opcode is decoded.
REQ-018 inst_count  output  CNT_W  meaning number of completed instructions.

Function
REQ-019 Every output SHALL be decoded only from registered state (state_num, internal IR, counters); there SHALL be no combinational path from any input to any output.
REQ-020 In IDLE with run=1, the block SHALL enter S1 on the next edge; otherwise it SHALL stay in IDLE.
REQ-021 S1: sel_pc=1, mem_read=1.
REQ-022 S2: sel_pc=1, mem_read=1, ld_inst=1, ld_inc=1; the internal IR SHALL capture inst_in at the edge ending S2.
REQ-023 S3: sel_pc=1, mem_read=1; ld_inst=0, ld_inc=0.
REQ-024 S4: decode cycle; no strobes asserted except per REQ-028 and REQ-030.
REQ-025 In S5 the block SHALL assert sel_inc=1 and ld_pc=1 for every opcode; in S6 it SHALL assert sel_inc=1.
REQ-026 MOV8, encoding 00dddsss: S5 ld_reg[ddd]=1 and sel_reg[sss]=1; S6 sel_reg[sss]=1. If ddd==sss, the load and select SHALL still both be asserted.
REQ-027 SETAB, encoding 01rvvvvv: imm_out = sign-extend(vvvvv) to DATA_W, valid S4..S6; imm_en=1 in S5..S6; S5 ld_reg[r]=1 (r=0 selects A, r=1 selects B).
REQ-028 ALU, encoding 1000rfff: alu_func=fff in S4..S6; S5 ld_reg[0]=1 when r=0, ld_reg[3]=1 when r=1.
REQ-029 alu_func SHALL equal 3'b111 in all other states and for all other opcodes.
REQ-030 All other opcodes (1001xxxx..1111xxxx) SHALL be treated as NOP: only the PC strobes of REQ-025; illegal=1 in S4 only.
REQ-031 S7..S(CYCLES_PER_INST) SHALL assert no strobes.
REQ-032 At most one ld_reg bit and at most one sel_reg bit SHALL be set in any cycle.
REQ-033 At the edge ending the last cycle, inst_count SHALL increment by 1, wrapping from all-ones to 0.
REQ-034 At that same edge, the next state SHALL be S1 if run=1 and step=0, and IDLE otherwise.
REQ-035 After a step completes, a new instruction SHALL start only when run is observed at 0 and then at 1 (rising request).
REQ-036 Deasserting run mid-instruction SHALL NOT abort the instruction; the block SHALL stop at the instruction boundary.

Reset
REQ-037 While reset=1, the block SHALL immediately (asynchronously) set: state IDLE; IR 8'h00; all strobes 0; ld_reg=0; sel_reg=0; alu_func=3'b111; imm_out=0; illegal=0; inst_count=0; step-rearm flag cleared.
REQ-038 Reset asserted mid-instruction SHALL abandon the instruction without incrementing inst_count.

Verification
REQ-039 Reset, run=1, inst_in=8'h01 (MOV A,B) -> S5: ld_reg=8'h01, sel_reg=8'h02, ld_pc=1; inst_count=1 after 8 cycles; next cycle state_num=1.
REQ-040 inst_in=8'b0111_1110 (SETAB B,-2), DATA_W=8 -> S5: ld_reg=8'h02, imm_en=1, imm_out=8'hFE.
REQ-041 inst_in=8'b1000_1010 (ALU, function 2, load D) -> alu_func=3'b010 in S4..S6, ld_reg=8'h08 in S5, alu_func=3'b111 in S7.
REQ-042 step=1, run held 1 -> exactly one instruction then IDLE, busy=0, inst_count+1; run 0->1 -> next instruction starts.
REQ-043 reset pulsed in S5 of a MOV -> all outputs at reset values before the next edge, inst_count unchanged at 0.
REQ-044 CYCLES_PER_INST=12, inst_in=8'hC0 -> illegal=1 in S4 only, no ld_reg, S9..S12 idle, S1 at cycle 13; inst_count at 16'hFFFF wraps to 0.
